// File: rtl/min_pkg.sv
// Shared types and constants for the windowed running-minimum sequencer.
package min_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      RESULT  = 2'd2
   } state_e;

   localparam int unsigned MAX_WIDTH = 64;

   // All-ones value of the given width, right-aligned; used as the running-min start value.
   function automatic logic [MAX_WIDTH-1:0] min_init(input int unsigned width);
      logic [MAX_WIDTH-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
         if (i < width) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/min_track_core.sv
// Running-minimum register with clear and update enable.
module min_track_core
   import min_pkg::*;
#(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             update,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] min_val,
   output logic [WIDTH-1:0] min_next,
   output logic             is_zero
);

   localparam logic [MAX_WIDTH-1:0] INIT_FULL = min_init(WIDTH);
   localparam logic [WIDTH-1:0]     MIN_INIT  = INIT_FULL[WIDTH-1:0];

   logic [WIDTH-1:0] min_q, min_d;

   // Candidate minimum including the sample offered this cycle; equal values keep the old min.
   always_comb begin
      min_next = min_q;
      if (update && (data < min_q)) min_next = data;
   end

   // Clear wins over update so a new window always starts from all-ones.
   always_comb begin
      min_d = min_next;
      if (clear) min_d = MIN_INIT;
   end

   // Running-minimum register.
   always_ff @(posedge clk) begin
      if (rst) min_q <= MIN_INIT;
      else     min_q <= min_d;
   end

   assign min_val = min_q;
   assign is_zero = (min_q == '0);

endmodule

// File: rtl/min_window_ctrl.sv
// Splits a valid/ready sample stream into fixed windows and returns each window's minimum.
module min_window_ctrl
   import min_pkg::*;
#(
   parameter int unsigned WIDTH  = 2,
   parameter int unsigned WINDOW = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             run,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             min_zero,
   output logic             busy
);

   localparam int unsigned CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] m_data_q, m_data_d;
   logic             accept, last, clear;
   logic [WIDTH-1:0] min_val, min_next;
   logic             is_zero;

   assign accept = s_valid && s_ready;
   assign last   = (cnt_q == CW'(WINDOW - 1));

   min_track_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .update   (accept),
      .data     (s_data),
      .min_val  (min_val),
      .min_next (min_next),
      .is_zero  (is_zero)
   );

   // State, counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         m_data_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         m_data_q <= m_data_d;
      end
   end

   // Next-state: abort overrides everything, start only counts in IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = COLLECT;
         COLLECT: if (accept && last) state_d = RESULT;
         RESULT:  if (m_ready) state_d = run ? COLLECT : IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   // Outputs decoded from the current state; abort blocks any sample in its cycle.
   always_comb begin
      s_ready  = (state_q == COLLECT) && !abort;
      m_valid  = (state_q == RESULT);
      busy     = (state_q != IDLE);
      min_zero = (state_q != IDLE) && is_zero;
   end

   // Counter, min clear and result capture; the captured result includes the last sample.
   always_comb begin
      cnt_d    = cnt_q;
      m_data_d = m_data_q;
      clear    = abort || ((state_q != COLLECT) && (state_d == COLLECT));
      if (abort || (state_q != COLLECT)) begin
         cnt_d = '0;
      end else if (accept) begin
         cnt_d = last ? '0 : cnt_q + CW'(1);
      end
      if (accept && last) m_data_d = min_next;
   end

   assign m_data = m_data_q;

endmodule
